// File: rtl/cia_pkg.sv
// Shared register-map offsets, CR bit positions and the CR layout for the CIA timer bank.
package cia_pkg;
  localparam int REG_STRIDE  = 8;
  localparam int OFF_LATCH0  = 0;
  localparam int OFF_LATCH1  = 1;
  localparam int OFF_LATCH2  = 2;
  localparam int OFF_LATCH3  = 3;
  localparam int OFF_CR      = 4;

  localparam int CR_START    = 0;
  localparam int CR_OUT_EN   = 1;
  localparam int CR_TOGGLE   = 2;
  localparam int CR_ONESHOT  = 3;
  localparam int CR_LOAD     = 4;
  localparam int CR_SRC      = 5;
  localparam int CR_CASCADE  = 6;

  localparam int ICR_SET_BIT = 7;

  typedef struct packed {
    logic rsvd;
    logic cascade;
    logic src;
    logic load;
    logic oneshot;
    logic toggle;
    logic out_en;
    logic start;
  } cr_t;
endpackage

// File: rtl/cia_timer_chan.sv
// One timer channel: latch, down-counter, two-stage count pipeline and CR.
// TIMER_OUT_EN adds the registered tmr_out pin and its toggle flop.
module cia_timer_chan
  import cia_pkg::*;
#(
  parameter int TIMER_W  = 16,
  parameter int CHAN_IDX = 0
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       wr_en,
  input  logic [2:0] off,
  input  logic [7:0] wr_dat,
  input  logic       cnt_evt,
  input  logic       cascade_in,
  output logic [7:0] rd_dat,
  output logic       uf_out
`ifdef TIMER_OUT_EN
  , output logic     tmr_out
`endif
);
  localparam int NB = TIMER_W / 8;

  cr_t               cr, cr_w;
  logic [TIMER_W-1:0] latch, latch_nxt, counter;
  logic              evt_q, load_pend, sel_casc, dec_evt, wr_cr;

  assign wr_cr    = wr_en && (off == 3'(OFF_CR));
  assign sel_casc = (CHAN_IDX != 0) && cr.cascade;
  assign dec_evt  = phi2_p && !load_pend && (sel_casc ? (cr.start && cascade_in) : evt_q);
  assign uf_out   = res_n && dec_evt && (counter == '0);

  always_comb begin
    latch_nxt = latch;
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (int'(off) == b) latch_nxt[b*8 +: 8] = wr_dat;
  end

  always_comb begin
    cr_w         = cr_t'(wr_dat);
    cr_w.load    = 1'b0;
    cr_w.rsvd    = 1'b0;
    if (CHAN_IDX == 0) cr_w.cascade = 1'b0;
`ifndef TIMER_OUT_EN
    cr_w.out_en  = 1'b0;
    cr_w.toggle  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      latch     <= '1;
      counter   <= '1;
      cr        <= '0;
      evt_q     <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      latch <= latch_nxt;
      if (phi2_p) begin
        // A one-shot underflow must not leave an event queued behind it.
        evt_q <= cr.start && (cr.src ? cnt_evt : 1'b1) && !(uf_out && cr.oneshot);
        if (load_pend) begin
          counter   <= latch_nxt;
          load_pend <= 1'b0;
        end else if (uf_out) begin
          counter <= latch_nxt;
        end else if (dec_evt) begin
          counter <= counter - 1'b1;
        end
        if (uf_out && cr.oneshot) cr.start <= 1'b0;
      end
      if (wr_en && (off == 3'(NB - 1)) && !cr.start) counter <= latch_nxt;
      if (wr_cr) begin
        cr <= cr_w;
        if (wr_dat[CR_LOAD]) load_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    for (int b = 0; b < NB; b++)
      if (int'(off) == b) rd_dat = counter[b*8 +: 8];
    if (off == 3'(OFF_CR)) rd_dat = cr;
  end

`ifdef TIMER_OUT_EN
  logic tog;
  always_ff @(posedge clk) begin
    if (!res_n) begin
      tog     <= 1'b0;
      tmr_out <= 1'b0;
    end else begin
      if (phi2_p) begin
        if (uf_out) tog <= ~tog;
        tmr_out <= cr.out_en && (cr.toggle ? (tog ^ uf_out) : uf_out);
      end
      if (wr_cr && wr_dat[CR_START] && !cr.start) tog <= 1'b1;
    end
  end
`endif
endmodule

// File: rtl/cia_timer_bank.sv
// NUM_TIMERS cascadable CIA-style interval timers with a shared ICR/IMR and 8-bit bus.
// Define TIMER_OUT_EN to add the per-channel tmr_out pulse/toggle outputs.
module cia_timer_bank
  import cia_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W    = 16,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  phi2_p,
  input  logic                  phi2_n,
  input  logic                  cs_n,
  input  logic                  rw,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  input  logic                  cnt_in,
  output logic [NUM_TIMERS-1:0] tmr_uf,
  output logic                  irq_n
`ifdef TIMER_OUT_EN
  , output logic [NUM_TIMERS-1:0] tmr_out
`endif
);
  localparam int ICR_ADDR = NUM_TIMERS * REG_STRIDE;

  logic                  wr, rd, icr_sel, clr_pend, cnt_s, cnt_prev, cnt_evt;
  logic [NUM_TIMERS-1:0] uf_vec, casc, flags, flags_nxt, imr;
  logic [7:0]            chan_rd [NUM_TIMERS];
  logic [7:0]            rd_mux, icr_rd;

  assign wr      = phi2_n && !cs_n && !rw;
  assign rd      = phi2_n && !cs_n && rw;
  assign icr_sel = (addr == ADDR_W'(ICR_ADDR));
  assign cnt_evt = cnt_s && !cnt_prev;
  assign tmr_uf  = uf_vec;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    if (i == 0) begin : g_first
      assign casc[i] = 1'b0;
    end else begin : g_next
      assign casc[i] = uf_vec[i-1];
    end
    cia_timer_chan #(.TIMER_W(TIMER_W), .CHAN_IDX(i)) u_chan (
      .clk        (clk),
      .res_n      (res_n),
      .phi2_p     (phi2_p),
      .wr_en      (wr && (addr[ADDR_W-1:3] == (ADDR_W-3)'(i))),
      .off        (addr[2:0]),
      .wr_dat     (db_in),
      .cnt_evt    (cnt_evt),
      .cascade_in (casc[i]),
      .rd_dat     (chan_rd[i]),
      .uf_out     (uf_vec[i])
`ifdef TIMER_OUT_EN
      , .tmr_out  (tmr_out[i])
`endif
    );
  end

  // Flags raised in the clearing phi2_p survive the pending ICR-read clear.
  assign flags_nxt = (clr_pend ? '0 : flags) | uf_vec;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      flags    <= '0;
      imr      <= '0;
      irq_n    <= 1'b1;
      clr_pend <= 1'b0;
      cnt_s    <= 1'b0;
      cnt_prev <= 1'b0;
    end else begin
      if (wr && icr_sel)
        imr <= db_in[ICR_SET_BIT] ? (imr | db_in[NUM_TIMERS-1:0]) : (imr & ~db_in[NUM_TIMERS-1:0]);
      if (phi2_p) begin
        cnt_s    <= cnt_in;
        cnt_prev <= cnt_s;
        flags    <= flags_nxt;
        clr_pend <= 1'b0;
        if (|(flags_nxt & imr)) irq_n <= 1'b0;
        else if (clr_pend)      irq_n <= 1'b1;
      end
      if (rd && icr_sel) clr_pend <= 1'b1;
    end
  end

  always_comb begin
    icr_rd                 = 8'h00;
    icr_rd[NUM_TIMERS-1:0] = flags;
    icr_rd[7]              = !irq_n;
    rd_mux                 = 8'h00;
    for (int i = 0; i < NUM_TIMERS; i++)
      if (int'(addr[ADDR_W-1:3]) == i) rd_mux = chan_rd[i];
    if (icr_sel) rd_mux = icr_rd;
  end

  assign db_out = (!cs_n && rw) ? rd_mux : 8'h00;
endmodule

// File: doc/cia_timer_bank.md
Name: cia_timer_bank

Overview:
- Parametrised successor to the 6526-style interval timers: NUM_TIMERS independent down-counters of TIMER_W bits, sharing one CIA-style interrupt control register (ICR/IMR).
- Per-channel features: continuous/one-shot mode, force-load, count source select (phi2 or CNT edge), and cascading from the previous channel's underflow.
- Sits on the 8-bit CPU bus beside the port/TOD logic. Clocked on the system clock with phi2_p/phi2_n enables.

Parameters:
- NUM_TIMERS, 2, number of channels (1..7).
- TIMER_W, 16, counter/latch width in bits (8, 16, 24 or 32).
- ADDR_W, 6, register address width; must satisfy 2^ADDR_W > NUM_TIMERS*8.

Ports:
- clk  in  1  system clock
- res_n  in  1  synchronous active-low reset
- phi2_p  in  1  one-clk enable at phi2 rising edge
- phi2_n  in  1  one-clk enable at phi2 falling edge (bus access strobe)
- cs_n  in  1  chip select, active low
- rw  in  1  1=read, 0=write
- addr  in  ADDR_W  register address
- db_in  in  8  write data
- db_out  out  8  read data (combinational from addr)
- cnt_in  in  1  external CNT pin
- tmr_uf  out  NUM_TIMERS  per-channel underflow, combinational, valid in phi2_p cycle
- irq_n  out  1  interrupt request, active low

Behaviour:
- Access qualification: wr = phi2_n & !cs_n & !rw; rd = phi2_n & !cs_n & rw.
- Register map: channel i occupies base i*8.
  - +0..+3: latch bytes, little-endian. Bytes at or above TIMER_W/8 are ignored on write and read as 0.
  - +4: CR. +5..+7: reserved, read 0.
  - ICR sits at NUM_TIMERS*8; IMR shares the address on write.
  - Unmapped reads return 0x00.
- Reads at +0..+3 return the live counter, not the latch.
- CR bits:
  - [0] START.
  - [1] OUT_EN (only with TIMER_OUT_EN).
  - [2] TOGGLE (only with TIMER_OUT_EN).
  - [3] ONESHOT.
  - [4] LOAD: strobe, always reads 0.
  - [5] SRC: 0=phi2, 1=CNT rising edge.
  - [6] CASCADE: count on underflow of channel i-1. Ignored for channel 0, where it reads 0.
  - [7] reserved, reads 0.
- Reset (res_n=0 at clk edge), all channels and shared state:
  - latch=all ones, counter=all ones, CR=0x00, IMR=0, ICR flags=0.
  - irq_n=1, tmr_uf=0, db_out=0x00.
- Count pipeline, advanced only on phi2_p:
  - Stage 0: qualify the event (START & source).
  - Stage 1: decrement.
  - A write setting START takes effect with the first decrement on the 2nd phi2_p after the write.
  - CNT edge is detected with a registered cnt_in_prev sampled on phi2_p. It adds 1 further stage of delay.
  - Cascade events use the previous channel's tmr_uf in the same phi2_p cycle, giving zero added delay.
- Underflow: a decrement event while counter==0 asserts tmr_uf[i].
  - In the same phi2_p: counter <= latch and ICR flag[i] <= 1.
  - If ONESHOT: START cleared and the pending pipeline event killed.
  - Latch=0 in continuous mode underflows on every qualified event.
- Load rules:
  - LOAD strobe: counter <= latch on the next phi2_p, and the decrement in that cycle is suppressed.
  - Writing the top byte while START=0: counter <= latch immediately (same clk).
  - Writing the low byte during an underflow phi2_p cycle: the reload uses the new byte.
- ICR write: bit7=1 sets the IMR bits given by db_in[NUM_TIMERS-1:0]; bit7=0 clears them. The new IMR is applied at the next phi2_p.
- ICR read:
  - Returns {irq_active, 0s, flags}.
  - Schedules a clear: at the next phi2_p, flags <= 0 and irq_n <= 1.
  - A flag set in that same phi2_p survives, because set beats clear.
- irq_n: at phi2_p, driven to 0 when |(flags & IMR). Stays low until an ICR read.
- Reset mid-count aborts all pipelines; no tmr_uf pulse is emitted in the reset cycle.

Optional Feature:
- Macro: TIMER_OUT_EN.
- When defined:
  - Adds output tmr_out[NUM_TIMERS-1:0], registered on phi2_p, reset 0.
  - With OUT_EN=1 and TOGGLE=0: tmr_out pulses high for one phi2 cycle per underflow.
  - With OUT_EN=1 and TOGGLE=1: tmr_out inverts per underflow. The toggle flop is set to 1 when START goes 0→1.
  - With OUT_EN=0: tmr_out=0.
- When undefined: the port is absent, CR[2:1] read 0, and no toggle state is built.

Decomposition:
- Package cia_pkg holds:
  - register offset constants (REG_STRIDE=8, OFF_LATCH0..3, OFF_CR);
  - CR bit index constants;
  - ICR bit7 constant;
  - a cr_t packed struct typedef.
- Sub-module cia_timer_chan (one channel: latch, counter, pipeline, CR, optional toggle).
- The top instantiates it NUM_TIMERS times and chains uf_out to the next channel's cascade_in. The ICR, IMR and bus mux stay in the top.

Test Plan:
- Continuous: ch0 latch=0x0003, CR=0x11 (START|LOAD) → tmr_uf[0] pulses every 4 phi2 cycles; counter reads 3,2,1,0,3…
- One-shot + IRQ: IMR write 0x81; ch0 latch=0x0002, CR=0x19 → single underflow, START reads 0, irq_n low on that phi2_p; ICR read returns 0x81, and irq_n=1 after the next phi2_p.
- Cascade: ch0 latch=1 continuous; ch1 latch=2, CR=0x51 → ch1 underflows once per 3 ch0 underflows (every 6 phi2 cycles).
- Set beats clear: ICR read in the same phi2_p that ch1 underflows → flag[1] remains set, irq_n stays 0, and the next read returns bit1=1.
- CNT source: ch0 CR=0x21, latch=0; 5 cnt_in rising edges → 5 underflows; with cnt_in held high, no counting occurs.
- TIMER_OUT_EN toggle: CR=0x07, latch=1 → tmr_out[0] starts at 1 and inverts every 2 phi2 cycles; a mid-run reset forces tmr_out=0, irq_n=1 and CR=0x00.
